mem_wait_ctrl: RTL and testbench

MEM_WAIT_CTRL -- requirements
Module: mem_wait_ctrl

---
 rtl/mem_wait_ctrl_pkg.sv | 9 +
 rtl/mem_wait_ctrl_if.sv | 27 ++
 rtl/mem_region_decode.sv | 14 +
 rtl/mem_wait_ctrl.sv | 88 ++++++++
 tb/tb_mem_wait_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mem_wait_ctrl_pkg.sv
// mem_wait_ctrl_pkg: shared FSM/region encodings and default address-map bases
// Holds the k-prefixed address-map constants used as parameter defaults by the
// controller and its region decoder.
package mem_wait_ctrl_pkg;
  localparam logic [7:0] k_io_base = 8'hD0;
  localparam logic [7:0] k_rom_base = 8'hE0;
  typedef enum logic [1:0] {ST_RUN, ST_ROM_WAIT, ST_IO_WAIT, ST_IO_DONE} state_t;
  typedef enum logic [1:0] {RGN_RAM, RGN_ROM, RGN_IO} region_t;
endpackage

// File: rtl/mem_wait_ctrl_if.sv
// mem_wait_ctrl_if: CPU-side and memory/IO-side bus of the wait-state controller
// master : controller view (drives cpu_ready/cpu_data_i, mem strobe, io_req, bus_err)
// slave  : CPU core plus RAM/ROM/IO devices
interface mem_wait_ctrl_if;
  logic [15:0] cpu_address_next;
  logic        cpu_write_next;
  logic [7:0]  cpu_data_o_next;
  logic        cpu_ready;
  logic [7:0]  cpu_data_i;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  rom_rdata;
  logic        io_req;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        bus_err;
  modport master (
    input  cpu_address_next, cpu_write_next, cpu_data_o_next, mem_rdata, rom_rdata, io_ack, io_rdata,
    output cpu_ready, cpu_data_i, mem_addr, mem_we, mem_wdata, io_req, bus_err
  );
  modport slave (
    output cpu_address_next, cpu_write_next, cpu_data_o_next, mem_rdata, rom_rdata, io_ack, io_rdata,
    input  cpu_ready, cpu_data_i, mem_addr, mem_we, mem_wdata, io_req, bus_err
  );
endinterface

// File: rtl/mem_region_decode.sv
// mem_region_decode: combinational address -> region classifier (IO > ROM > RAM)
// addr_hi : address[15:12]
// region  : RGN_IO for the 4 KB IO_BASE page, RGN_ROM for the 8 KB ROM_BASE window, else RGN_RAM
module mem_region_decode
  import mem_wait_ctrl_pkg::*;
#(
  parameter logic [7:0] IO_BASE = k_io_base,
  parameter logic [7:0] ROM_BASE = k_rom_base
) (
  input  logic [3:0] addr_hi,
  output region_t    region
);
  always_comb region = addr_hi == IO_BASE[7:4] ? RGN_IO : addr_hi[3:1] == ROM_BASE[7:5] ? RGN_ROM : RGN_RAM;
endmodule

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: CPU bus wait-state controller for RAM, slow ROM and handshaked IO
// clk   : rising-edge clock
// reset : asynchronous active-low reset
// bus   : mem_wait_ctrl_if.master (CPU next-cycle request, ready/data back, RAM/ROM strobe, IO handshake)
// Optional: define MEM_WAIT_TIMEOUT_EN to abort IO accesses after IO_TIMEOUT unacknowledged cycles
// (io_req drops, bus_err pulses in the following cycle, read data 8'hFF).
module mem_wait_ctrl
  import mem_wait_ctrl_pkg::*;
#(
  parameter int ROM_WAIT = 1,
  parameter int IO_TIMEOUT = 15,
  parameter logic [7:0] IO_BASE = k_io_base,
  parameter logic [7:0] ROM_BASE = k_rom_base
) (
  input logic clk,
  input logic reset,
  mem_wait_ctrl_if.master bus
);
  state_t state, state_nx;
  region_t region, region_dec;
  logic [2:0] wait_cnt, wait_cnt_nx;
  logic [7:0] io_data, io_data_nx;
  logic ready, expire;
  if (ROM_WAIT < 0 || ROM_WAIT > 7 || IO_TIMEOUT < 1 || IO_TIMEOUT > 255) begin : g_param_err
    $error("mem_wait_ctrl: ROM_WAIT or IO_TIMEOUT out of range");
  end
  mem_region_decode #(.IO_BASE(IO_BASE), .ROM_BASE(ROM_BASE)) u_decode (
    .addr_hi(bus.cpu_address_next[15:12]),
    .region (region_dec)
  );
`ifdef MEM_WAIT_TIMEOUT_EN
  logic [7:0] to_cnt;
  // io_ack in the expiry cycle takes precedence over the abort
  assign expire = state == ST_IO_WAIT && !bus.io_ack && to_cnt == 8'(IO_TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      to_cnt <= '0;
      bus.bus_err <= 1'b0;
    end else begin
      to_cnt <= state == ST_IO_WAIT && !expire ? to_cnt + 8'd1 : 8'd0;
      bus.bus_err <= expire;
    end
`else
  assign expire = 1'b0;
  assign bus.bus_err = 1'b0;
`endif
  assign ready = state == ST_RUN || state == ST_IO_DONE;
  assign bus.cpu_ready = ready;
  assign bus.io_req = state == ST_IO_WAIT;
  assign bus.cpu_data_i = region == RGN_IO ? io_data : region == RGN_ROM ? bus.rom_rdata : bus.mem_rdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_RUN;
      region <= RGN_RAM;
      wait_cnt <= '0;
      io_data <= 8'hFF;
      bus.mem_addr <= '0;
      bus.mem_we <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_cnt_nx;
      io_data <= io_data_nx;
      if (ready) begin
        region <= region_dec;
        bus.mem_addr <= bus.cpu_address_next;
        bus.mem_we <= bus.cpu_write_next && region_dec != RGN_IO;
        bus.mem_wdata <= bus.cpu_data_o_next;
      end
    end
  // IO_DONE has cpu_ready=1, so it dispatches the next access exactly like RUN
  always_comb begin
    state_nx = state;
    wait_cnt_nx = '0;
    io_data_nx = io_data;
    if (ready) begin
      state_nx = region_dec == RGN_IO ? ST_IO_WAIT :
                 region_dec == RGN_ROM && !bus.cpu_write_next && ROM_WAIT > 0 ? ST_ROM_WAIT : ST_RUN;
      wait_cnt_nx = 3'(ROM_WAIT - 1);
    end else if (state == ST_ROM_WAIT) begin
      state_nx = wait_cnt == 3'd0 ? ST_RUN : ST_ROM_WAIT;
      wait_cnt_nx = wait_cnt == 3'd0 ? 3'd0 : wait_cnt - 3'd1;
    end else if (bus.io_ack || expire) begin
      state_nx = ST_IO_DONE;
      io_data_nx = bus.io_ack ? bus.io_rdata : 8'hFF;
    end
  end
endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb_mem_wait_ctrl: directed + randomized self-checking bench for mem_wait_ctrl
module tb_mem_wait_ctrl;
  localparam int rom_wait = 2;
  localparam int io_timeout = 15;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] ram [0:65535];
  bit ram_vld [0:65535];
  logic [7:0] ref_mem [logic [15:0]];
  mem_wait_ctrl_if bus();
  mem_wait_ctrl #(.ROM_WAIT(rom_wait), .IO_TIMEOUT(io_timeout), .IO_BASE(8'hD0), .ROM_BASE(8'hE0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]};
  endfunction
  function automatic logic [7:0] rom_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  always @(posedge clk)
    if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
      ram_vld[bus.mem_addr] <= 1'b1;
    end
  assign bus.mem_rdata = ram_vld[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
  assign bus.rom_rdata = rom_val(bus.mem_addr);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_cpu_ready"}, bus.cpu_ready, 1);
    check({tag, "_io_req"}, bus.io_req, 0);
    check({tag, "_bus_err"}, bus.bus_err, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask
  // One CPU access issued from a negedge where cpu_ready=1; ack_at=0 means never acknowledge.
  task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d, input int ack_at,
                        input logic [7:0] io_val);
    bit io, rom;
    int stalls = 0, reqs = 0, errs = 0, wes = 0, exp_stalls;
    logic [7:0] exp_data;
    io = a[15:12] == 4'hD;
    rom = !io && a[15:13] == 3'b111;
    exp_stalls = io ? (ack_at == 0 ? io_timeout : ack_at) : (rom && !w ? rom_wait : 0);
    exp_data = io ? (ack_at == 0 ? 8'hFF : io_val) : rom ? rom_val(a) :
               (ref_mem.exists(a) ? ref_mem[a] : init_val(a));
    bus.cpu_address_next = a;
    bus.cpu_write_next = w;
    bus.cpu_data_o_next = d;
    @(posedge clk);
    @(negedge clk);
    check("mem_addr", bus.mem_addr, a);
    check("mem_we", bus.mem_we, w && !io);
    if (w) check("mem_wdata", bus.mem_wdata, d);
    while (!bus.cpu_ready && stalls < 40) begin
      stalls++;
      reqs += bus.io_req;
      errs += bus.bus_err;
      wes += bus.mem_we;
      bus.cpu_address_next = 16'($urandom);
      bus.cpu_write_next = 1'($urandom);
      bus.cpu_data_o_next = 8'($urandom);
      if (io && stalls == ack_at) begin
        bus.io_ack = 1'b1;
        bus.io_rdata = io_val;
      end
      @(negedge clk);
      bus.io_ack = 1'b0;
      bus.io_rdata = 8'($urandom);
    end
    errs += bus.bus_err;
    check("stall_cycles", stalls, exp_stalls);
    check("io_req_cycles", reqs, io ? exp_stalls : 0);
    check("bus_err_pulses", errs, io && ack_at == 0);
    check("mem_we_during_wait", wes, 0);
    check("io_req_after", bus.io_req, 0);
    check("addr_held", bus.mem_addr, a);
    if (!w || io) check("cpu_data_i", bus.cpu_data_i, exp_data);
    if (w && !io) ref_mem[a] = d;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.cpu_address_next = '0;
    bus.cpu_write_next = 1'b0;
    bus.cpu_data_o_next = '0;
    bus.io_ack = 1'b0;
    bus.io_rdata = '0;
    #3 reset = 1'b0;
    #1 check_reset("reset");
    @(negedge clk);
    reset = 1'b1;
    access(16'h1234, 1'b0, 8'h00, 0, 8'h00);
    access(16'hFFFC, 1'b0, 8'h00, 0, 8'h00);
    access(16'hD020, 1'b0, 8'h00, 3, 8'h5A);
`ifdef MEM_WAIT_TIMEOUT_EN
    access(16'hD400, 1'b1, 8'h0F, 0, 8'h00);
    access(16'hD020, 1'b0, 8'h00, 0, 8'h00);
`endif
    access(16'hD400, 1'b1, 8'h0F, io_timeout, 8'hC3);
    access(16'hD7FF, 1'b0, 8'h00, 1, 8'h96);
    access(16'h0040, 1'b1, 8'hA7, 0, 8'h00);
    access(16'h0040, 1'b0, 8'h00, 0, 8'h00);
    access(16'hE010, 1'b1, 8'h99, 0, 8'h00);
    access(16'hE010, 1'b0, 8'h00, 0, 8'h00);
    access(16'hCFFF, 1'b0, 8'h00, 0, 8'h00);
    bus.io_ack = 1'b1;
    bus.io_rdata = 8'h77;
    access(16'h2000, 1'b0, 8'h00, 0, 8'h00);
    bus.io_ack = 1'b0;
    bus.cpu_address_next = 16'hD100;
    bus.cpu_write_next = 1'b0;
    @(posedge clk);
    repeat (2) @(negedge clk);
    check("io_req_before_reset", bus.io_req, 1);
    #2 reset = 1'b0;
    #1 check_reset("reset_in_io_wait");
    @(negedge clk);
    reset = 1'b1;
    bus.cpu_address_next = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    check("ready_in_rom_wait", bus.cpu_ready, 0);
    #2 reset = 1'b0;
    #1 check_reset("reset_in_rom_wait");
    @(negedge clk);
    reset = 1'b1;
    access(16'hFFFE, 1'b0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 40; i++) begin
      int r, ack;
      logic [15:0] a;
      r = $urandom_range(0, 3);
      a = r == 0 ? 16'hD000 + 16'($urandom_range(0, 4095)) :
          r == 1 ? 16'hFFF0 + 16'($urandom_range(0, 3)) : 16'h1230 + 16'($urandom_range(0, 3));
`ifdef MEM_WAIT_TIMEOUT_EN
      ack = $urandom_range(0, 5);
`else
      ack = $urandom_range(1, 5);
`endif
      access(a, 1'($urandom), 8'($urandom), ack, 8'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
